// File: rtl/uart_fifo_core.sv
// uart_fifo_core
// Byte-oriented 8N1 UART sitting behind the memory-mapped UART data/status
// addresses. A TX FIFO feeds a serializer. A deserializer feeds an RX FIFO.
// Status flags and the RX head byte are read combinationally by the memory block.
//
// Ports:
//   clk                 single clock, all state on its rising edge
//   rst                 asynchronous active-low reset
//   uart_fifo_write_en  one-cycle strobe, pushes uart_fifo_data into the TX FIFO
//   uart_fifo_data      byte to transmit
//   cpu_read            one-cycle strobe, pops the RX FIFO head
//   rx_line             serial input (asynchronous, idle high)
//   tx_line             registered serial output (idle high)
//   tx_ready            TX FIFO not full
//   rx_ready            RX FIFO not empty; doubles as the external interrupt request
//   rx_data_output      {24'b0, RX head byte}, zero when the RX FIFO is empty
//   rx_overrun          sticky: a good frame was dropped because the RX FIFO was full
module uart_fifo_core #(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_fifo_write_en,
  input  logic [7:0]  uart_fifo_data,
  input  logic        cpu_read,
  input  logic        rx_line,
  output logic        tx_line,
  output logic        tx_ready,
  output logic        rx_ready,
  output logic [31:0] rx_data_output,
  output logic        rx_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // ---------------- TX side ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_count;
  logic [1:0]    tx_state;
  logic [BW-1:0] tx_clk_cnt;
  logic [2:0]    tx_bit_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end, tx_push, tx_pop;

  assign tx_bit_end = (tx_clk_cnt == BIT_LAST);
  // Full is judged on the registered count, so a push while full is lost even
  // if the serializer pops in the same cycle.
  assign tx_push    = uart_fifo_write_en && (tx_count != FULL);
  // Popping in the last stop-bit cycle lets the next start bit follow the stop
  // bit with no idle gap.
  assign tx_pop     = (tx_count != '0) &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
  assign tx_ready   = (tx_count != FULL);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= uart_fifo_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // tx_line is registered from the current state, so the line trails the
  // state by one cycle; every bit therefore still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= TX_IDLE;
      tx_clk_cnt <= '0;
      tx_bit_idx <= '0;
      tx_shift   <= '0;
      tx_line    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (tx_pop) begin
            tx_shift   <= tx_mem[tx_rptr];
            tx_clk_cnt <= '0;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          tx_line <= 1'b0;
          if (tx_bit_end) begin
            tx_clk_cnt <= '0;
            tx_bit_idx <= '0;
            tx_state   <= TX_DATA;
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          tx_line <= tx_shift[0];
          if (tx_bit_end) begin
            tx_clk_cnt <= '0;
            tx_shift   <= {1'b0, tx_shift[7:1]};
            if (tx_bit_idx == 3'd7) tx_state <= TX_STOP;
            else                    tx_bit_idx <= tx_bit_idx + 1'b1;
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          tx_line <= 1'b1;
          if (tx_bit_end) begin
            tx_clk_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rptr];
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX side ----------------
  logic          rx_sync1, rx_sync2;
  logic [1:0]    rx_warm;
  logic          rx_armed;
  logic [1:0]    rx_state;
  logic [BW-1:0] rx_clk_cnt;
  logic [2:0]    rx_bit_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_count;
  logic          rx_frame_ok, rx_push, rx_pop;

  assign rx_frame_ok    = (rx_state == RX_STOP) && (rx_clk_cnt == BIT_LAST) && rx_sync2;
  assign rx_push        = rx_frame_ok && (rx_count != FULL);
  assign rx_pop         = cpu_read && (rx_count != '0);
  assign rx_ready       = (rx_count != '0);
  assign rx_data_output = (rx_count != '0) ? {24'b0, rx_mem[rx_rptr]} : 32'b0;

  // rx_warm marks when the synchronizer holds real line samples again after
  // reset, so the reset value of 1 cannot fake a high-to-low transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_warm  <= 2'b00;
    end else begin
      rx_sync1 <= rx_line;
      rx_sync2 <= rx_sync1;
      rx_warm  <= {rx_warm[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      if (rx_frame_ok && (rx_count == FULL)) rx_overrun <= 1'b1;
    end
  end

  // A start needs the line seen high while idle (rx_armed) and then low. This
  // ignores a line already low after reset or after a framing error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_clk_cnt <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_armed   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_armed && !rx_sync2) begin
            rx_armed   <= 1'b0;
            rx_clk_cnt <= '0;
            rx_bit_idx <= '0;
            rx_state   <= RX_START;
          end else if (rx_warm[1] && rx_sync2) begin
            rx_armed <= 1'b1;
          end
        end
        RX_START: begin
          if (rx_clk_cnt == HALF_LAST) begin
            rx_clk_cnt <= '0;
            rx_state   <= rx_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_shift   <= {rx_sync2, rx_shift[7:1]};
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
            else                    rx_bit_idx <= rx_bit_idx + 1'b1;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_state   <= RX_IDLE;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core
// Self-checking bench for uart_fifo_core with DEPTH=4 and CLKS_PER_BIT=4.
// A line monitor turns tx_line back into bytes. RX frames are driven bit by
// bit. Expected values come from constant tables and from a queue-based model.
module tb_uart_fifo_core;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  localparam int OP_GOOD   = 0;
  localparam int OP_BAD    = 1;
  localparam int OP_GLITCH = 2;
  localparam int OP_READ   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        cpu_read = 1'b0;
  logic        rx_line = 1'b1;
  logic        tx_line, tx_ready, rx_ready, rx_overrun;
  logic [31:0] rx_data_output;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] txGot[$];
  int         txStart[$];
  logic [7:0] txExp[$];
  logic [7:0] rxModel[$];
  logic       ovrModel;

  typedef struct {
    int          op;
    logic [7:0]  b;
    logic        expReady;
    logic [31:0] expData;
    logic        expOvr;
  } rxVec_t;

  rxVec_t vecs[16];

  uart_fifo_core #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .uart_fifo_write_en(we),
    .uart_fifo_data(wdata),
    .cpu_read(cpu_read),
    .rx_line(rx_line),
    .tx_line(tx_line),
    .tx_ready(tx_ready),
    .rx_ready(rx_ready),
    .rx_data_output(rx_data_output),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeTx(input logic [7:0] b);
    we = 1'b1;
    wdata = b;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic popRx();
    cpu_read = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    idle(6);
  endtask

  task automatic sendGlitch();
    rx_line = 1'b0;
    idle(2);
    rx_line = 1'b1;
    idle(12);
  endtask

  task automatic applyStimulus(input int op, input logic [7:0] b);
    case (op)
      OP_GOOD:   sendRxFrame(b, 1'b1);
      OP_BAD:    sendRxFrame(b, 1'b0);
      OP_GLITCH: sendGlitch();
      default:   popRx();
    endcase
  endtask

  task automatic checkRxModel(input string tag);
    checkOutput({tag, " rx_ready"}, rx_ready, rxModel.size() > 0);
    checkOutput({tag, " rx_data_output"}, rx_data_output,
                rxModel.size() > 0 ? {24'b0, rxModel[0]} : 32'b0);
    checkOutput({tag, " rx_overrun"}, rx_overrun, ovrModel);
  endtask

  task automatic waitTxFrames(input int n);
    int budget;
    budget = n * FRAME + 200;
    while (txGot.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("tx frame count", txGot.size(), n);
  endtask

  task automatic compareTx();
    for (int i = 0; i < txExp.size() && i < txGot.size(); i++)
      checkOutput($sformatf("tx byte %0d", i), txGot[i], txExp[i]);
    txGot.delete();
    txStart.delete();
    txExp.delete();
  endtask

  // Line monitor: captures 40 cycles from each falling edge, decodes mid-bit
  // samples, and checks the whole waveform has the ideal 8N1 shape.
  initial begin : txMonitor
    logic [FRAME-1:0] wave;
    logic [FRAME-1:0] want;
    logic [7:0] b;
    int st;
    int idx;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_line === 1'b0) begin
        st = cyc;
        wave = '0;
        aborted = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          wave[k] = tx_line;
        end
        if (!aborted) begin
          for (int i = 0; i < 8; i++) b[i] = wave[CPB * (i + 1) + CPB / 2];
          for (int k = 0; k < FRAME; k++) begin
            idx = k / CPB;
            want[k] = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx - 1];
          end
          checkOutput("tx frame shape", wave, want);
          txGot.push_back(b);
          txStart.push_back(st);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int wEdge;
    int op;
    logic [7:0] rb;

    vecs[0]  = '{OP_GOOD,   8'h3C, 1'b1, 32'h0000003C, 1'b0};
    vecs[1]  = '{OP_READ,   8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{OP_BAD,    8'h55, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{OP_GLITCH, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{OP_GOOD,   8'h81, 1'b1, 32'h00000081, 1'b0};
    vecs[5]  = '{OP_READ,   8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[6]  = '{OP_GOOD,   8'h11, 1'b1, 32'h00000011, 1'b0};
    vecs[7]  = '{OP_GOOD,   8'h22, 1'b1, 32'h00000011, 1'b0};
    vecs[8]  = '{OP_GOOD,   8'h33, 1'b1, 32'h00000011, 1'b0};
    vecs[9]  = '{OP_GOOD,   8'h44, 1'b1, 32'h00000011, 1'b0};
    vecs[10] = '{OP_GOOD,   8'h55, 1'b1, 32'h00000011, 1'b1};
    vecs[11] = '{OP_READ,   8'h00, 1'b1, 32'h00000022, 1'b1};
    vecs[12] = '{OP_READ,   8'h00, 1'b1, 32'h00000033, 1'b1};
    vecs[13] = '{OP_READ,   8'h00, 1'b1, 32'h00000044, 1'b1};
    vecs[14] = '{OP_READ,   8'h00, 1'b0, 32'h00000000, 1'b1};
    vecs[15] = '{OP_READ,   8'h00, 1'b0, 32'h00000000, 1'b1};

    #2 rst = 1'b0;
    idle(2);
    checkOutput("reset tx_line", tx_line, 1'b1);
    checkOutput("reset tx_ready", tx_ready, 1'b1);
    checkOutput("reset rx_ready", rx_ready, 1'b0);
    checkOutput("reset rx_data_output", rx_data_output, 32'h0);
    checkOutput("reset rx_overrun", rx_overrun, 1'b0);
    rst = 1'b1;
    idle(2);

    // Single byte: start bit appears two edges after the write edge.
    writeTx(8'hA5);
    wEdge = cyc;
    txExp.push_back(8'hA5);
    waitTxFrames(1);
    if (txStart.size() > 0) checkOutput("tx latency", txStart[0], wEdge + 2);
    compareTx();
    idle(5);

    // Fill the TX FIFO while a frame is already on the line.
    writeTx(8'h10);
    txExp.push_back(8'h10);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      we = 1'b1;
      wdata = 8'h20 + 8'(i);
      @(negedge clk);
      if (i == 2) checkOutput("tx_ready after 3rd", tx_ready, 1'b1);
      if (i == 3) checkOutput("tx_ready after 4th", tx_ready, 1'b0);
      if (i < 4) txExp.push_back(8'h20 + 8'(i));
    end
    we = 1'b0;
    waitTxFrames(5);
    idle(60);
    checkOutput("tx no extra frame", txGot.size(), 5);
    checkOutput("tx_ready drained", tx_ready, 1'b1);
    for (int i = 1; i < txStart.size(); i++)
      checkOutput($sformatf("tx back-to-back gap %0d", i),
                  txStart[i] - txStart[i - 1], FRAME);
    compareTx();

    // RX vector table.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].b);
      checkOutput($sformatf("vec%0d rx_ready", i), rx_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d rx_data_output", i), rx_data_output, vecs[i].expData);
      checkOutput($sformatf("vec%0d rx_overrun", i), rx_overrun, vecs[i].expOvr);
    end

    // Reset in the middle of a TX frame and an RX frame.
    writeTx(8'h77);
    rx_line = 1'b0;
    idle(12);
    rst = 1'b0;
    #1;
    checkOutput("midreset tx_line", tx_line, 1'b1);
    checkOutput("midreset tx_ready", tx_ready, 1'b1);
    checkOutput("midreset rx_ready", rx_ready, 1'b0);
    checkOutput("midreset rx_data_output", rx_data_output, 32'h0);
    checkOutput("midreset rx_overrun", rx_overrun, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(8);
    rx_line = 1'b1;
    idle(60);
    checkOutput("no rx byte after reset", rx_ready, 1'b0);
    checkOutput("no aborted tx frame", txGot.size(), 0);
    txGot.delete();
    txStart.delete();
    writeTx(8'hC3);
    txExp.push_back(8'hC3);
    waitTxFrames(1);
    compareTx();
    sendRxFrame(8'h96, 1'b1);
    checkOutput("post-reset rx_data_output", rx_data_output, 32'h96);
    popRx();
    checkOutput("post-reset rx_ready after pop", rx_ready, 1'b0);

    // Randomized mix checked against the queue model.
    ovrModel = 1'b0;
    for (int it = 0; it < 24; it++) begin
      op = int'($urandom_range(0, 4));
      rb = 8'($urandom);
      case (op)
        0, 1: begin
          sendRxFrame(rb, 1'b1);
          if (rxModel.size() < DEPTH) rxModel.push_back(rb);
          else ovrModel = 1'b1;
        end
        2: sendRxFrame(rb, 1'b0);
        3: begin
          popRx();
          if (rxModel.size() > 0) void'(rxModel.pop_front());
        end
        default: begin
          writeTx(rb);
          txExp.push_back(rb);
          idle(FRAME);
        end
      endcase
      checkRxModel($sformatf("rand%0d", it));
    end
    waitTxFrames(txExp.size());
    compareTx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
